// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU front-panel controller.
//   state_t      - controller FSM states (encoding visible on state_o)
//   OP_*         - ALU operation codes carried on alu_sel
//   ALU_LAT_DEF  - default ALU latency in cycles
//   dd_step      - one shift-and-add-3 step of a 5-bit double-dabble
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GOT_A   = 3'd1,
    GOT_B   = 3'd2,
    EXEC    = 3'd3,
    CAPTURE = 3'd4,
    CONVERT = 3'd5,
    SHOW    = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_REM = 2'b11;

  localparam int ALU_LAT_DEF = 1;

  // Shift register layout: {tens[3:0], ones[3:0], bin[4:0]}.
  // A 5-bit value never exceeds 31, so the tens digit never reaches 8 and
  // its top bit can be dropped on the shift.
  function automatic logic [12:0] dd_step(input logic [12:0] s);
    logic [3:0] t;
    logic [3:0] o;
    t = s[12:9];
    o = s[8:5];
    if (o >= 4'd5) o = o + 4'd3;
    if (t >= 4'd5) t = t + 4'd3;
    return {t[2:0], o, s[4:0], 1'b0};
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: bus between the controller and the external ALU.
//   alu_num1/alu_num2 - operands (controller -> ALU)
//   alu_sel           - operation code (controller -> ALU)
//   alu_result        - 5-bit result (ALU -> controller)
//   alu_zero          - result-is-zero flag (ALU -> controller)
//   alu_divzero       - remainder by zero flag (ALU -> controller)
// master: controller side, slave: ALU side.
interface alu_ctrl_if;
  logic [2:0] alu_num1;
  logic [2:0] alu_num2;
  logic [1:0] alu_sel;
  logic [4:0] alu_result;
  logic       alu_zero;
  logic       alu_divzero;

  modport master (
    output alu_num1, alu_num2, alu_sel,
    input  alu_result, alu_zero, alu_divzero
  );

  modport slave (
    input  alu_num1, alu_num2, alu_sel,
    output alu_result, alu_zero, alu_divzero
  );
endinterface

// File: rtl/bcd_conv.sv
// bcd_conv: sequential 5-bit binary to two-digit BCD converter
// (double-dabble, one bit per cycle).
//   clk, rst_n - clock, asynchronous active-low reset
//   abort      - synchronous cancel of a conversion in progress
//   start      - load bin; conversion runs on the following 5 cycles
//   bin        - binary value to convert
//   done       - high during the cycle whose edge completes the conversion
//   tens, ones - registered digits, updated only when a conversion finishes
module bcd_conv
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       start,
  input  logic [4:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [12:0] shift_reg;
  logic [2:0]  cnt_reg;
  logic        busy_reg;
  logic [12:0] step;

  assign step = dd_step(shift_reg);
  assign done = busy_reg && (cnt_reg == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      tens      <= '0;
      ones      <= '0;
    end else if (abort) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      shift_reg <= {8'd0, bin};
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (busy_reg) begin
      shift_reg <= step;
      cnt_reg   <= cnt_reg + 3'd1;
      if (done) begin
        busy_reg <= 1'b0;
        tens     <= step[12:9];
        ones     <= step[8:5];
      end
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: front-panel controller for a small ALU. Two operands and an
// operation are entered from switches with an enter button; the operands
// are held on the ALU for ALU_LAT cycles, the result is captured, sign and
// error flags are derived, and the magnitude is converted to BCD.
//   clk, rst_n           - clock, asynchronous active-low reset
//   sw_data, sw_sel      - operand value and operation code switches
//   enter                - level button, rising edge acts
//   clear                - synchronous abort to IDLE
//   alu                  - ALU bus (master side)
//   res_valid            - converted result is being shown
//   res_value            - captured result magnitude
//   res_tens, res_ones   - BCD digits of res_value
//   res_neg, zero_flag, err_flag - sign, zero, divide-by-zero
//   state_o              - FSM state (debug)
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_data,
  input  logic [1:0] sw_sel,
  input  logic       enter,
  input  logic       clear,
  alu_ctrl_if.master alu,
  output logic       res_valid,
  output logic [4:0] res_value,
  output logic [3:0] res_tens,
  output logic [3:0] res_ones,
  output logic       res_neg,
  output logic       zero_flag,
  output logic       err_flag,
  output logic [2:0] state_o
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_t     state_reg;
  logic       enter_q;
  logic       armed_reg;
  logic [3:0] wait_cnt_reg;
  logic       enter_edge;
  logic [4:0] cap_value;
  logic       cap_neg;
  logic       bcd_start;
  logic       bcd_done;

  // armed_reg stays low after reset until enter has been seen low, so a
  // button still held across reset release cannot register as a press.
  assign enter_edge = enter & ~enter_q & armed_reg;
  assign state_o    = state_reg;

  // Result interpretation: negative differences are shown as magnitude
  // plus sign; a divide-by-zero forces the value to 0.
  always_comb begin
    cap_value = alu.alu_result;
    cap_neg   = 1'b0;
    if (alu.alu_divzero) begin
      cap_value = '0;
    end else if (alu.alu_sel == OP_SUB && alu.alu_result[4]) begin
      cap_neg   = 1'b1;
      cap_value = ~alu.alu_result + 5'd1;
    end
  end

  // Conversion is launched from CAPTURE so that CONVERT spans exactly the
  // five shift cycles.
  assign bcd_start = (state_reg == CAPTURE) && !clear;

  bcd_conv u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (clear),
    .start (bcd_start),
    .bin   (cap_value),
    .done  (bcd_done),
    .tens  (res_tens),
    .ones  (res_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      enter_q      <= 1'b0;
      armed_reg    <= 1'b0;
      wait_cnt_reg <= '0;
      alu.alu_num1 <= '0;
      alu.alu_num2 <= '0;
      alu.alu_sel  <= '0;
      res_valid    <= 1'b0;
      res_value    <= '0;
      res_neg      <= 1'b0;
      zero_flag    <= 1'b0;
      err_flag     <= 1'b0;
    end else begin
      enter_q <= enter;
      if (!enter) armed_reg <= 1'b1;

      if (clear) begin
        state_reg    <= IDLE;
        wait_cnt_reg <= '0;
        alu.alu_num1 <= '0;
        alu.alu_num2 <= '0;
        alu.alu_sel  <= '0;
        res_valid    <= 1'b0;
        res_neg      <= 1'b0;
        zero_flag    <= 1'b0;
        err_flag     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (enter_edge) begin
            alu.alu_num1 <= sw_data;
            state_reg    <= GOT_A;
          end
          GOT_A: if (enter_edge) begin
            alu.alu_num2 <= sw_data;
            state_reg    <= GOT_B;
          end
          GOT_B: if (enter_edge) begin
            alu.alu_sel  <= sw_sel;
            wait_cnt_reg <= '0;
            state_reg    <= EXEC;
          end
          EXEC: begin
            if (wait_cnt_reg == LAT_LAST) state_reg <= CAPTURE;
            else wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
          CAPTURE: begin
            res_value <= cap_value;
            res_neg   <= cap_neg;
            zero_flag <= alu.alu_zero & ~alu.alu_divzero;
            err_flag  <= alu.alu_divzero;
            state_reg <= CONVERT;
          end
          CONVERT: if (bcd_done) begin
            res_valid <= 1'b1;
            state_reg <= SHOW;
          end
          SHOW: if (enter_edge) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed-vector bench for alu_ctrl. The bench plays the ALU
// by driving fixed result/flag values for each vector.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw_data = '0;
  logic [1:0] sw_sel = '0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       res_valid;
  logic [4:0] res_value;
  logic [3:0] res_tens;
  logic [3:0] res_ones;
  logic       res_neg;
  logic       zero_flag;
  logic       err_flag;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_ctrl_if alu_bus ();

  alu_ctrl #(.ALU_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_data   (sw_data),
    .sw_sel    (sw_sel),
    .enter     (enter),
    .clear     (clear),
    .alu       (alu_bus),
    .res_valid (res_valid),
    .res_value (res_value),
    .res_tens  (res_tens),
    .res_ones  (res_ones),
    .res_neg   (res_neg),
    .zero_flag (zero_flag),
    .err_flag  (err_flag),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic press(input logic [2:0] v);
    sw_data = v;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
    tick();
  endtask

  // Enter both operands, launch the operation; returns with state in EXEC.
  task automatic launch(input logic [2:0] a, input logic [2:0] b,
                        input logic [1:0] sel);
    press(a);
    press(b);
    sw_sel = sel;
    enter  = 1'b1;
    tick();
    enter  = 1'b0;
  endtask

  task automatic run_op(input string name,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [1:0] sel, input logic [4:0] res,
                        input logic z, input logic dz,
                        input int e_val, input int e_tens, input int e_ones,
                        input int e_neg, input int e_zero, input int e_err);
    int cyc;
    alu_bus.alu_result  = res;
    alu_bus.alu_zero    = z;
    alu_bus.alu_divzero = dz;
    launch(a, b, sel);
    check({name, " state EXEC"}, int'(state_o), 3);
    check({name, " num1"}, int'(alu_bus.alu_num1), int'(a));
    check({name, " num2"}, int'(alu_bus.alu_num2), int'(b));
    check({name, " sel"}, int'(alu_bus.alu_sel), int'(sel));
    cyc = 0;
    while (state_o != 3'd6 && cyc < 50) begin
      tick();
      cyc++;
    end
    check({name, " latency"}, cyc, LAT + 6);
    check({name, " res_valid"}, int'(res_valid), 1);
    check({name, " value"}, int'(res_value), e_val);
    check({name, " tens"}, int'(res_tens), e_tens);
    check({name, " ones"}, int'(res_ones), e_ones);
    check({name, " neg"}, int'(res_neg), e_neg);
    check({name, " zero"}, int'(zero_flag), e_zero);
    check({name, " err"}, int'(err_flag), e_err);
    // leave SHOW: valid drops, result holds
    enter = 1'b1;
    tick();
    enter = 1'b0;
    check({name, " exit state"}, int'(state_o), 0);
    check({name, " exit valid"}, int'(res_valid), 0);
    check({name, " hold value"}, int'(res_value), e_val);
    tick();
  endtask

  initial begin
    int hits;
    alu_bus.alu_result  = '0;
    alu_bus.alu_zero    = 1'b0;
    alu_bus.alu_divzero = 1'b0;
    tick();
    tick();
    check("reset state", int'(state_o), 0);
    check("reset valid", int'(res_valid), 0);
    check("reset num1", int'(alu_bus.alu_num1), 0);
    rst_n = 1'b1;
    tick();
    tick();

    run_op("add 3+4",  3'd3, 3'd4, OP_ADD, 5'd7,  1'b0, 1'b0, 7, 0, 7, 0, 0, 0);
    run_op("mul 6*5",  3'd6, 3'd5, OP_MUL, 5'd30, 1'b0, 1'b0, 30, 3, 0, 0, 0, 0);
    run_op("rem 5%0",  3'd5, 3'd0, OP_REM, 5'd0,  1'b1, 1'b1, 0, 0, 0, 0, 0, 1);
    run_op("sub 3-3",  3'd3, 3'd3, OP_SUB, 5'd0,  1'b1, 1'b0, 0, 0, 0, 0, 1, 0);
    run_op("sub 2-5",  3'd2, 3'd5, OP_SUB, 5'b11101, 1'b0, 1'b0, 3, 0, 3, 1, 0, 0);

    // held enter gives exactly one edge
    sw_data = 3'd1;
    enter   = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("held enter state", int'(state_o), 1);
    enter = 1'b0;
    tick();

    // clear with coincident enter during CONVERT
    press(3'd2);
    sw_sel = OP_ADD;
    alu_bus.alu_result = 5'd3;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    check("in CONVERT", int'(state_o), 5);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    check("clear state", int'(state_o), 0);
    check("clear num1", int'(alu_bus.alu_num1), 0);
    check("clear neg", int'(res_neg), 0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) hits++;
    end
    check("clear valid never", hits, 0);
    check("clear stays idle", int'(state_o), 0);

    // async reset mid-EXEC (previous result was 3 with neg cleared)
    launch(3'd3, 3'd4, OP_ADD);
    check("pre-reset EXEC", int'(state_o), 3);
    rst_n = 1'b0;
    #1;
    check("async rst state", int'(state_o), 0);
    check("async rst num1", int'(alu_bus.alu_num1), 0);
    check("async rst sel+num2", int'({alu_bus.alu_num2, alu_bus.alu_sel}), 0);
    check("async rst value", int'(res_value), 0);
    check("async rst digits", int'({res_tens, res_ones}), 0);
    check("async rst flags",
          int'({res_valid, res_neg, zero_flag, err_flag}), 0);

    // enter held across reset release is not a press
    enter = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("held over reset", int'(state_o), 0);
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    check("fresh press", int'(state_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
